// File: rtl/pipe_stage_chain_if.sv
// Bundle of the pipeline-register chain signals: fetch handshake, the
// per-boundary next-payload bus, stall/flush requests, the registered
// payload/valid/advance outputs and the three performance counters.
// The master side is the surrounding CPU datapath; the slave side is the
// register chain itself.
interface pipe_stage_chain_if #(
   parameter int NUM_STAGES = 4,
   parameter int PAYLOAD_W  = 160,
   parameter int CNT_W      = 32
);

   logic                            in_valid;
   logic                            in_ready;
   logic [NUM_STAGES*PAYLOAD_W-1:0] stage_d;
   logic [NUM_STAGES-1:0]           stall_req;
   logic [NUM_STAGES-1:0]           flush_req;
   logic [NUM_STAGES*PAYLOAD_W-1:0] stage_q;
   logic [NUM_STAGES-1:0]           valid_q;
   logic [NUM_STAGES-1:0]           adv_q;
   logic [CNT_W-1:0]                stall_cnt;
   logic [CNT_W-1:0]                flush_cnt;
   logic [CNT_W-1:0]                retire_cnt;

   modport master (
      output in_valid,
      output stage_d,
      output stall_req,
      output flush_req,
      input  in_ready,
      input  stage_q,
      input  valid_q,
      input  adv_q,
      input  stall_cnt,
      input  flush_cnt,
      input  retire_cnt
   );

   modport slave (
      input  in_valid,
      input  stage_d,
      input  stall_req,
      input  flush_req,
      output in_ready,
      output stage_q,
      output valid_q,
      output adv_q,
      output stall_cnt,
      output flush_cnt,
      output retire_cnt
   );

endinterface

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of pipeline registers. Register k sits between stage k
// and stage k+1 and carries a payload word plus a valid bit. The highest set
// stall bit freezes every register at or below it and injects a bubble into
// the register just above it; the highest set flush bit kills every register
// at or below it and takes priority over any stall.
// Optional feature macro: PIPE_PERF_CNT_EN builds saturating stall, flush and
// retire counters; without it those outputs are tied to zero.
module pipe_stage_chain #(
   parameter int NUM_STAGES = 4,
   parameter int PAYLOAD_W  = 160,
   parameter int CNT_W      = 32
) (
   input logic                clk,
   input logic                rst,
   pipe_stage_chain_if.slave  bus
);

   logic [NUM_STAGES-1:0][PAYLOAD_W-1:0] r_stageQ;
   logic [NUM_STAGES-1:0]                r_validQ;
   logic [NUM_STAGES-1:0]                r_advQ;

   logic [NUM_STAGES-1:0][PAYLOAD_W-1:0] w_stageD;
   logic [NUM_STAGES-1:0]                w_kill;
   logic [NUM_STAGES-1:0]                w_hold;
   logic [NUM_STAGES-1:0]                w_bubble;
   logic [NUM_STAGES-1:0]                w_validSrc;

   assign w_stageD = bus.stage_d;

   // Each advancing register takes its valid bit from the register below it;
   // register 0 takes the fetch valid.
   assign w_validSrc = {r_validQ[NUM_STAGES-2:0], bus.in_valid};

   // Register k is killed when any flush bit at index k or above is set and
   // frozen when any stall bit at index k or above is set, which is exactly
   // "k is at or below the highest set bit". The bubble lands on the register
   // whose immediate lower neighbour carries the highest stall bit.
   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_ctrl
      assign w_kill[k] = |(bus.flush_req >> k);
      assign w_hold[k] = |(bus.stall_req >> k);
      if (k == 0) begin : g_noBubble
         assign w_bubble[k] = 1'b0;
      end else begin : g_bubble
         assign w_bubble[k] = bus.stall_req[k-1] & ~w_hold[k];
      end
   end

   // Fetch may only hand over a new instruction when nothing stalls or flushes.
   assign bus.in_ready = ~(|bus.stall_req) & ~(|bus.flush_req);

   // Per-register update in priority order: flush, stall hold, bubble, advance.
   // A flushed register keeps its stale payload; only its valid bit drops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stageQ <= '0;
         r_validQ <= '0;
         r_advQ   <= '0;
      end else begin
         for (int j = 0; j < NUM_STAGES; j++) begin
            if (w_kill[j]) begin
               r_validQ[j] <= 1'b0;
               r_advQ[j]   <= 1'b0;
            end else if (w_hold[j]) begin
               r_advQ[j]   <= 1'b0;
            end else if (w_bubble[j]) begin
               r_stageQ[j] <= w_stageD[j];
               r_validQ[j] <= 1'b0;
               r_advQ[j]   <= 1'b1;
            end else begin
               r_stageQ[j] <= w_stageD[j];
               r_validQ[j] <= w_validSrc[j];
               r_advQ[j]   <= 1'b1;
            end
         end
      end
   end

   assign bus.stage_q = r_stageQ;
   assign bus.valid_q = r_validQ;
   assign bus.adv_q   = r_advQ;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] r_stallCnt;
   logic [CNT_W-1:0] r_flushCnt;
   logic [CNT_W-1:0] r_retireCnt;
   logic             w_retire;

   // A word retires when the last register holds a valid word and is neither
   // frozen by its own stall bit nor killed by a whole-chain flush.
   assign w_retire = r_validQ[NUM_STAGES-1] & ~bus.stall_req[NUM_STAGES-1]
                   & ~bus.flush_req[NUM_STAGES-1];

   // Saturating event counters; they stick at all-ones until the next reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stallCnt  <= '0;
         r_flushCnt  <= '0;
         r_retireCnt <= '0;
      end else begin
         if ((|bus.stall_req) && !(&r_stallCnt)) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
         end
         if ((|bus.flush_req) && !(&r_flushCnt)) begin
            r_flushCnt <= r_flushCnt + CNT_W'(1);
         end
         if (w_retire && !(&r_retireCnt)) begin
            r_retireCnt <= r_retireCnt + CNT_W'(1);
         end
      end
   end

   assign bus.stall_cnt  = r_stallCnt;
   assign bus.flush_cnt  = r_flushCnt;
   assign bus.retire_cnt = r_retireCnt;
`else
   // Counter logic is not built; the ports remain and read as zero.
   assign bus.stall_cnt  = '0;
   assign bus.flush_cnt  = '0;
   assign bus.retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed testbench for pipe_stage_chain with four 16-bit registers and
// 4-bit counters. Each register's next payload is driven as the tag of the
// word that would enter it; expected values are written out by hand.
module tb_pipe_stage_chain;

   localparam int NS = 4;
   localparam int PW = 16;
   localparam int CW = 4;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   pipe_stage_chain_if #(.NUM_STAGES(NS), .PAYLOAD_W(PW), .CNT_W(CW)) bus ();

   pipe_stage_chain #(.NUM_STAGES(NS), .PAYLOAD_W(PW), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counter expectations collapse to zero when the counters are not built.
   function automatic logic [CW-1:0] expCnt(input logic [CW-1:0] v);
`ifdef PIPE_PERF_CNT_EN
      return v;
`else
      return '0;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs and let combinational outputs settle.
   task automatic applyStimulus(input logic iv, input logic [15:0] d0, input logic [15:0] d1,
                                input logic [15:0] d2, input logic [15:0] d3,
                                input logic [3:0] st, input logic [3:0] fl);
      bus.in_valid  = iv;
      bus.stage_d   = {d3, d2, d1, d0};
      bus.stall_req = st;
      bus.flush_req = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkState(input string tag, input logic [63:0] q, input logic [3:0] v,
                             input logic [3:0] a);
      checkOutput({tag, " stage_q"}, 64'(bus.stage_q), q);
      checkOutput({tag, " valid_q"}, 64'(bus.valid_q), 64'(v));
      checkOutput({tag, " adv_q"},   64'(bus.adv_q),   64'(a));
   endtask

   task automatic checkCounters(input string tag, input logic [3:0] s, input logic [3:0] f,
                                input logic [3:0] r);
      checkOutput({tag, " stall_cnt"},  64'(bus.stall_cnt),  64'(expCnt(s)));
      checkOutput({tag, " flush_cnt"},  64'(bus.flush_cnt),  64'(expCnt(f)));
      checkOutput({tag, " retire_cnt"}, 64'(bus.retire_cnt), 64'(expCnt(r)));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      bus.in_valid  = 1'b0;
      bus.stage_d   = '0;
      bus.stall_req = '0;
      bus.flush_req = '0;

      // Reset state
      #2;
      checkState("reset", 64'h0, 4'b0000, 4'b0000);
      checkCounters("reset", 4'd0, 4'd0, 4'd0);
      checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      rst = 1'b1;

      // Streaming A0..A5
      applyStimulus(1'b1, 16'hA0, 16'h0, 16'h0, 16'h0, 4'b0, 4'b0);
      checkOutput("stream in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      checkState("edge1", 64'h0000_0000_0000_00A0, 4'b0001, 4'b1111);
      applyStimulus(1'b1, 16'hA1, 16'hA0, 16'h0, 16'h0, 4'b0, 4'b0);
      tick();
      applyStimulus(1'b1, 16'hA2, 16'hA1, 16'hA0, 16'h0, 4'b0, 4'b0);
      tick();
      checkState("edge3", 64'h0000_00A0_00A1_00A2, 4'b0111, 4'b1111);
      applyStimulus(1'b1, 16'hA3, 16'hA2, 16'hA1, 16'hA0, 4'b0, 4'b0);
      tick();
      checkState("edge4", 64'h00A0_00A1_00A2_00A3, 4'b1111, 4'b1111);
      applyStimulus(1'b1, 16'hA4, 16'hA3, 16'hA2, 16'hA1, 4'b0, 4'b0);
      tick();
      applyStimulus(1'b1, 16'hA5, 16'hA4, 16'hA3, 16'hA2, 4'b0, 4'b0);
      tick();
      checkState("edge6", 64'h00A2_00A3_00A4_00A5, 4'b1111, 4'b1111);
      checkCounters("edge6", 4'd0, 4'd0, 4'd2);

      // Load-use stall on boundary 1
      applyStimulus(1'b1, 16'hA6, 16'hA5, 16'hA4, 16'hA3, 4'b0010, 4'b0);
      checkOutput("stall in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      checkState("stall", 64'h00A3_00A4_00A4_00A5, 4'b1011, 4'b1100);
      checkCounters("stall", 4'd1, 4'd0, 4'd3);
      applyStimulus(1'b1, 16'hA6, 16'hA5, 16'hA4, 16'hA4, 4'b0, 4'b0);
      tick();
      checkState("unstall", 64'h00A4_00A4_00A5_00A6, 4'b0111, 4'b1111);

      // Redirect flush with a lower stall in the same cycle
      applyStimulus(1'b1, 16'hA7, 16'hA6, 16'hA5, 16'hA4, 4'b0001, 4'b0010);
      checkOutput("redirect in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      checkState("redirect", 64'h00A4_00A5_00A5_00A6, 4'b1100, 4'b1100);
      checkCounters("redirect", 4'd2, 4'd1, 4'd4);

      // Full-chain flush while the last register is valid
      applyStimulus(1'b1, 16'hB0, 16'hA6, 16'hA5, 16'hA5, 4'b0, 4'b1000);
      tick();
      checkState("fullflush", 64'h00A4_00A5_00A5_00A6, 4'b0000, 4'b0000);
      checkCounters("fullflush", 4'd2, 4'd2, 4'd4);

      // Refetch after the flush
      applyStimulus(1'b1, 16'hC0, 16'hA6, 16'hA5, 16'hA5, 4'b0, 4'b0);
      tick();
      checkState("refetch", 64'h00A5_00A5_00A6_00C0, 4'b0001, 4'b1111);

      // Top-boundary stall for 20 cycles: whole chain holds, no bubble
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 16'hD0, 16'hC0, 16'hA6, 16'hA5, 4'b1000, 4'b0);
         tick();
      end
      checkOutput("topstall in_ready", 64'(bus.in_ready), 64'd0);
      checkState("topstall", 64'h00A5_00A5_00A6_00C0, 4'b0001, 4'b0000);
      checkCounters("topstall", 4'hF, 4'd2, 4'd4);

      // Refill to a full chain
      applyStimulus(1'b1, 16'hD0, 16'hC0, 16'hA6, 16'hA5, 4'b0, 4'b0);
      tick();
      applyStimulus(1'b1, 16'hD1, 16'hD0, 16'hC0, 16'hA6, 4'b0, 4'b0);
      tick();
      applyStimulus(1'b1, 16'hD2, 16'hD1, 16'hD0, 16'hC0, 4'b0, 4'b0);
      tick();
      checkState("refill", 64'h00C0_00D0_00D1_00D2, 4'b1111, 4'b1111);
      checkCounters("refill", 4'hF, 4'd2, 4'd4);

      // Asynchronous reset mid-stream, observed before the next edge
      #2;
      rst = 1'b0;
      #1;
      checkState("asyncreset", 64'h0, 4'b0000, 4'b0000);
      checkCounters("asyncreset", 4'd0, 4'd0, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
